pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the program counter and sequences instruction fetch for the pipelined CPU. It decides each cycle whether the PC advances sequentially, takes a branch redirect from the ID stage, or holds for a hazard stall, and it runs the req/ready handshake with instruction memory. It also generates the IF/ID flush and valid strobes and counts accepted fetches. It replaces the free-running PC register plus next-PC select in front of the IF stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
INSTR_BYTES, 4, sequential PC increment in bytes.

Ports:
clk_i  input  1  clock, all state updates on rising edge.
rst_i  input  1  reset, synchronous, active-high.
start_i  input  1  leave IDLE and begin fetching.
stall_i  input  1  hazard-unit stall; hold PC and IF/ID.
branch_taken_i  input  1  ID-stage branch/jump resolved as taken.
branch_addr_i  input  32  branch/jump target.
imem_ready_i  input  1  instruction memory has returned the word at imem_addr_o this cycle.
imem_req_o  output  1  fetch request.
imem_addr_o  output  32  fetch address, equal to pc_o.
pc_o  output  32  current PC, registered.
pc_plus4_o  output  32  pc_o + INSTR_BYTES, combinational, wraps mod 2^32.
if_valid_o  output  1  registered one-cycle strobe: a new instruction entered IF/ID.
if_flush_o  output  1  registered one-cycle strobe: flush IF/ID.
halted_o  output  1  sticky misaligned-target error.
fetch_count_o  output  32  number of accepted sequential fetches.

Behaviour:
- One clock (clk_i). Reset (rst_i) is synchronous and active-high.
- Reset values: pc_o=RESET_PC, state=IDLE, if_valid_o=0, if_flush_o=0, halted_o=0, fetch_count_o=0. Reset asserted mid-fetch or mid-stall overrides everything at that edge.
- States are IDLE, FETCH and HALT. The state register is internal.
- imem_req_o = (state==FETCH). It is combinational from state, so it is 0 in IDLE and HALT.
- imem_addr_o = pc_o in all states.
- IDLE:
  - start_i=1 moves to FETCH at the next edge. pc_o is unchanged.
  - branch_taken_i, stall_i and imem_ready_i are ignored.
- FETCH: the following terms are defined.
  - mis = branch_taken_i & ~stall_i & (branch_addr_i[1:0]!=0)
  - redirect = branch_taken_i & ~stall_i & (branch_addr_i[1:0]==0)
  - adv = imem_ready_i & ~stall_i & ~branch_taken_i
- Priority is stall > branch > sequential advance.
  - stall_i=1 holds pc_o. It ignores branch_taken_i and imem_ready_i, and the word returned that cycle is dropped. ID holds the branch, so the branch is re-seen after the stall.
  - redirect: pc_o <= branch_addr_i and if_flush_o <= 1 for one cycle. Any simultaneous imem_ready_i word is discarded, so if_valid_o <= 0 and fetch_count_o is unchanged.
  - adv: pc_o <= pc_o + INSTR_BYTES (wraps 32'hFFFF_FFFC -> 0), if_valid_o <= 1 and fetch_count_o <= fetch_count_o + 1 (wraps).
  - If none of these applies, pc_o is held and both strobes are 0 next cycle.
- Memory handshake: the address may change while the request is outstanding. Memory samples the address only in the cycle it asserts imem_ready_i, so a redirect abandons the in-flight fetch without protocol error.
- mis (in FETCH): move to HALT, halted_o <= 1, if_flush_o <= 1 for one cycle, pc_o is unchanged.
- HALT:
  - imem_req_o=0 and the strobes are 0 after the flush pulse.
  - All inputs except rst_i are ignored. The only exit is reset.
- Latency: a redirect is visible on pc_o/imem_addr_o one cycle after branch_taken_i is sampled. The strobes appear in the same cycle as the new pc_o.

Test Plan:
- Reset/start: assert rst_i 2 cycles, then start_i=1 for 1 cycle, imem_ready_i=1 always -> pc_o=0 with imem_req_o=0 until start is sampled; then pc_o=0,4,8,12 on successive cycles, if_valid_o=1 each cycle, fetch_count_o=3 after three advances.
- Stall vs branch: at pc_o=0x10 drive stall_i=1 and branch_taken_i=1 with target 0x100 for 2 cycles, then stall_i=0 with the branch still asserted -> pc_o stays 0x10 during the stall, is 0x100 one cycle after release, and if_flush_o=1 for exactly that one cycle.
- Branch with ready: at pc_o=0x20 drive imem_ready_i=1 and branch_taken_i=1 with target 0x40 -> pc_o=0x40, if_flush_o=1, if_valid_o=0, fetch_count_o unchanged.
- Slow memory: imem_ready_i low 3 cycles, then high 1 cycle, at pc_o=0x8 -> pc_o is held at 0x8 with imem_req_o=1 for 3 cycles, then pc_o=0xC with a single if_valid_o pulse.
- Misalign/halt: branch target 0x102 -> halted_o=1, one if_flush_o pulse, imem_req_o=0, pc_o frozen despite start_i/imem_ready_i; a later rst_i returns pc_o to RESET_PC and halted_o to 0.
- Wrap: set RESET_PC=32'hFFFF_FFF8, start with imem_ready_i=1 -> pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4_o=0 while pc_o=FFFF_FFFC; reset asserted mid-sequence restores FFFF_FFF8 at the next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer.
// Selects sequential advance, branch redirect or stall hold, and runs the imem req/ready handshake.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned INSTR_BYTES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_addr_i,
    input  logic        imem_ready_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        if_valid_o,
    output logic        if_flush_o,
    output logic        halted_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

    localparam logic [31:0] Incr = 32'(INSTR_BYTES);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        flush_q, flush_d;
    logic        halted_q, halted_d;
    logic [31:0] count_q, count_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = 1'b0;
        flush_d  = 1'b0;
        halted_d = halted_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // Stall wins over everything; ID keeps the branch so it is re-seen afterwards.
                if (!stall_i) begin
                    if (branch_taken_i) begin
                        flush_d = 1'b1;
                        if (branch_addr_i[1:0] != 2'b00) begin
                            state_d  = StHalt;
                            halted_d = 1'b1;
                        end else begin
                            pc_d = branch_addr_i;
                        end
                    end else if (imem_ready_i) begin
                        pc_d    = pc_q + Incr;
                        valid_d = 1'b1;
                        count_d = count_q + 32'd1;
                    end
                end
            end
            StHalt: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign imem_req_o    = (state_q == StFetch);
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + Incr;
    assign if_valid_o    = valid_q;
    assign if_flush_o    = flush_q;
    assign halted_o      = halted_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default-reset instance plus a wrap-around instance.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, stall, br, ready;
    logic [31:0] addr;
    logic        req, valid, flush, halted;
    logic [31:0] iaddr, pc, pc4, count;

    logic        rst_w, start_w;
    logic        req_w, valid_w, flush_w, halted_w;
    logic [31:0] iaddr_w, pc_w, pc4_w, count_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
        .branch_taken_i(br), .branch_addr_i(addr), .imem_ready_i(ready),
        .imem_req_o(req), .imem_addr_o(iaddr), .pc_o(pc), .pc_plus4_o(pc4),
        .if_valid_o(valid), .if_flush_o(flush), .halted_o(halted), .fetch_count_o(count)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFF8), .INSTR_BYTES(4)) dut_w (
        .clk_i(clk), .rst_i(rst_w), .start_i(start_w), .stall_i(1'b0),
        .branch_taken_i(1'b0), .branch_addr_i(32'h0), .imem_ready_i(1'b1),
        .imem_req_o(req_w), .imem_addr_o(iaddr_w), .pc_o(pc_w), .pc_plus4_o(pc4_w),
        .if_valid_o(valid_w), .if_flush_o(flush_w), .halted_o(halted_w), .fetch_count_o(count_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic [31:0] e_pc, input logic e_req,
                            input logic e_valid, input logic e_flush, input logic e_halt,
                            input logic [31:0] e_cnt);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".addr"}, iaddr, e_pc);
        chk({tag, ".req"}, 32'(req), 32'(e_req));
        chk({tag, ".valid"}, 32'(valid), 32'(e_valid));
        chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
        chk({tag, ".halted"}, 32'(halted), 32'(e_halt));
        chk({tag, ".count"}, count, e_cnt);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; br = 1'b0; addr = 32'h0; ready = 1'b1;
        rst_w = 1'b1; start_w = 1'b0;

        // Reset and idle
        tick(); tick();
        chk_main("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        tick();
        chk_main("idle", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        start = 1'b1;
        tick();
        chk_main("start", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        start = 1'b0;
        tick(); chk_main("seq4", 32'h4, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1);
        tick(); chk_main("seq8", 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2);
        tick(); chk_main("seqC", 32'hC, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3);
        chk("pc_plus4", pc4, 32'h10);

        // Slow memory
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_main("slow_wait", 32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3);
        end
        ready = 1'b1;
        tick(); chk_main("slow_done", 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'd4);

        // Stall beats branch and ready
        stall = 1'b1; br = 1'b1; addr = 32'h100;
        tick(); chk_main("stall1", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4);
        tick(); chk_main("stall2", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4);
        stall = 1'b0;
        tick(); chk_main("redirect", 32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 32'd4);
        br = 1'b0; ready = 1'b0;
        tick(); chk_main("flush_end", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4);

        // Branch with simultaneous ready discards the word
        ready = 1'b1; br = 1'b1; addr = 32'h40;
        tick(); chk_main("br_ready", 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 32'd4);
        br = 1'b0;
        tick(); chk_main("after_br", 32'h44, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5);
        chk("pc_plus4_b", pc4, 32'h48);

        // Misaligned target halts
        br = 1'b1; addr = 32'h102;
        tick(); chk_main("mis", 32'h44, 1'b0, 1'b0, 1'b1, 1'b1, 32'd5);
        br = 1'b0; start = 1'b1;
        tick(); chk_main("halt1", 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
        br = 1'b1; addr = 32'h200;
        tick(); chk_main("halt2", 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
        br = 1'b0; start = 1'b0; rst = 1'b1;
        tick(); chk_main("halt_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;

        // Reset mid-stall overrides the stall
        start = 1'b1;
        tick(); start = 1'b0; stall = 1'b1;
        tick(); chk_main("pre_stall_rst", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        tick(); chk_main("stall_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0; stall = 1'b0;

        // Wrap-around instance
        tick();
        chk("wrap_reset_pc", pc_w, 32'hFFFF_FFF8);
        chk("wrap_reset_req", 32'(req_w), 32'd0);
        rst_w = 1'b0; start_w = 1'b1;
        tick();
        chk("wrap_start_pc", pc_w, 32'hFFFF_FFF8);
        chk("wrap_start_req", 32'(req_w), 32'd1);
        start_w = 1'b0;
        tick();
        chk("wrap_fffc", pc_w, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc4_w, 32'h0);
        chk("wrap_valid", 32'(valid_w), 32'd1);
        tick();
        chk("wrap_zero", pc_w, 32'h0);
        chk("wrap_count", count_w, 32'd2);
        tick();
        chk("wrap_four", pc_w, 32'h4);
        rst_w = 1'b1;
        tick();
        chk("wrap_rst_pc", pc_w, 32'hFFFF_FFF8);
        chk("wrap_rst_cnt", count_w, 32'd0);
        chk("wrap_rst_req", 32'(req_w), 32'd0);
        chk("wrap_halted", 32'(halted_w), 32'd0);
        chk("wrap_flush", 32'(flush_w), 32'd0);
        chk("wrap_addr", iaddr_w, 32'hFFFF_FFF8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
